// File: rtl/snn_pkg.sv
// snn_pkg: shared constants, state type and helpers for the spike encoder
package snn_pkg;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] t;
    t = {x, x} << s;
    return t[15:8];
  endfunction
endpackage

// File: rtl/spike_lfsr16.sv
// spike_lfsr16: 16-bit right-shifting Galois LFSR, seeded on reset, advanced on enable
module spike_lfsr16
  import snn_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q;
  assign state_o = lfsr_q;
  // Hold between steps so the sequence continues across RUN/IDLE transitions
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else if (en_i) lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
  end
endmodule

// File: rtl/spike_encoder.sv
// spike_encoder: rate-coding front end, stochastic (LFSR) or deterministic (accumulator)
module spike_encoder
  import snn_pkg::*;
#(
  parameter int          N_CH      = 8,
  parameter int          VAL_W     = 8,
  parameter int          WINDOW    = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  localparam int         AW        = N_CH > 1 ? $clog2(N_CH) : 1,
  localparam int         SW        = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VAL_W-1:0] wr_data,
  input  logic             run,
  input  logic             mode,
  output logic [N_CH-1:0]  spikes,
  output logic             spike_valid,
  output logic             window_done,
  output logic             busy
);
  state_e           state_q;
  logic             mode_q;
  logic [SW-1:0]    step_q;
  logic [VAL_W-1:0] intensity_q [N_CH];
  logic [VAL_W-1:0] acc_q [N_CH];
  logic [VAL_W-1:0] acc_d [N_CH];
  logic [N_CH-1:0]  spike_d;
  logic [15:0]      lfsr;
  logic             step;
  assign step = (state_q == RUN) && run;
  spike_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (step && !mode_q),
    .state_o(lfsr)
  );
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0]   rnd;
    logic [VAL_W:0] sum;
    assign rnd = rotl8(lfsr[15:8], 3'(i)) ^ lfsr[7:0];
    assign sum = {1'b0, acc_q[i]} + {1'b0, intensity_q[i]};
    assign acc_d[i] = sum[VAL_W-1:0];
    assign spike_d[i] = mode_q ? sum[VAL_W] : (intensity_q[i] > VAL_W'(rnd));
  end
  // Intensity register file; a step in the same cycle still sees the old value
  always_ff @(posedge clk) begin
    if (rst) intensity_q <= '{default: '0};
    else if (wr_en && 32'(wr_addr) < N_CH) intensity_q[wr_addr] <= wr_data;
  end
  // Control FSM with registered outputs; entering RUN restarts window and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      step_q      <= '0;
      acc_q       <= '{default: '0};
      spikes      <= '0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
      busy        <= 1'b0;
    end else if (state_q == IDLE) begin
      spikes      <= '0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
      if (run) begin
        state_q <= RUN;
        busy    <= 1'b1;
        mode_q  <= mode;
        step_q  <= '0;
        acc_q   <= '{default: '0};
      end
    end else if (run) begin
      spikes      <= spike_d;
      spike_valid <= 1'b1;
      window_done <= step_q == SW'(WINDOW - 1);
      step_q      <= step_q == SW'(WINDOW - 1) ? '0 : step_q + 1'b1;
      if (mode_q) acc_q <= acc_d;
    end else begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: scoreboard bench with a behavioural rate-coding reference model
module tb_spike_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       run = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] spikes;
  logic       spike_valid, window_done, busy;

  spike_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .run        (run),
    .mode       (mode),
    .spikes     (spikes),
    .spike_valid(spike_valid),
    .window_done(window_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] q[$];
  int m_int[8], m_acc[8], m_lfsr, m_step;
  logic m_run, m_mode;
  int cnt[8], wd_cnt;
  int base[8], wd_base;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_ge(string nm, int act, int lo);
    n_checks++;
    if (act < lo) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d", nm, act, lo);
    end
  endfunction

  // One clock: apply inputs, advance the reference model for the coming edge
  task automatic cyc(input logic rs, input logic rn, input logic md, input logic we,
                     input logic [2:0] a, input logic [7:0] d);
    logic [8:0] e;
    int hi, lo, r, s;
    rst = rs; run = rn; mode = md; wr_en = we; wr_addr = a; wr_data = d;
    if (rs) begin
      m_run = 0; m_mode = 0; m_lfsr = 'hACE1; m_step = 0;
      for (int c = 0; c < 8; c++) begin m_int[c] = 0; m_acc[c] = 0; end
    end else begin
      if (!m_run) begin
        if (rn) begin
          m_run = 1; m_mode = md; m_step = 0;
          for (int c = 0; c < 8; c++) m_acc[c] = 0;
        end
      end else if (!rn) m_run = 0;
      else begin
        e = '0;
        hi = m_lfsr / 256;
        lo = m_lfsr % 256;
        for (int c = 0; c < 8; c++) begin
          if (m_mode) begin
            s = m_acc[c] + m_int[c];
            e[c] = s >= 256;
            m_acc[c] = s % 256;
          end else begin
            r = (((hi << c) | (hi >> (8 - c))) % 256) ^ lo;
            e[c] = m_int[c] > r;
          end
        end
        if (!m_mode) m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 'hB400 : 0);
        e[8] = m_step == 15;
        m_step = (m_step + 1) % 16;
        q.push_back(e);
      end
      if (we) m_int[a] = d;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(0, 0, 0, 1, a, d);
  endtask

  task automatic runn(input logic md, input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, md, 0, 0, 0);
  endtask

  task automatic snap();
    for (int c = 0; c < 8; c++) base[c] = cnt[c];
    wd_base = wd_cnt;
  endtask

  initial begin
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    wd_cnt = 0;
    fork
      forever begin
        logic [8:0] e;
        @(negedge clk);
        if (!rst || m_run == 0) begin
          chk("busy", int'(busy), int'(m_run));
          chk("spike_valid", int'(spike_valid), int'(q.size() > 0));
          e = q.size() > 0 ? q.pop_front() : 9'h0;
          chk("spikes", int'(spikes), int'(e[7:0]));
          chk("window_done", int'(window_done), int'(e[8]));
          for (int c = 0; c < 8; c++) cnt[c] += int'(spikes[c]);
          wd_cnt += int'(window_done);
        end
      end
    join_none

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    wr(0, 8'd77); wr(5, 8'd200);
    runn(0, 6);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(2);
    snap();
    runn(1, 10);
    idle(2);
    chk("zero_intensity_ch0", cnt[0] - base[0], 0);

    cyc(1, 0, 0, 0, 0, 0);
    wr(0, 8'd128); wr(1, 8'd64); wr(2, 8'd255);
    snap();
    runn(1, 17);
    idle(2);
    chk("det_ch0_count", cnt[0] - base[0], 8);
    chk("det_ch1_count", cnt[1] - base[1], 4);
    chk("det_ch2_count", cnt[2] - base[2], 15);
    chk("det_window_once", wd_cnt - wd_base, 1);

    snap();
    runn(1, 41);
    idle(2);
    chk("window_40_steps", wd_cnt - wd_base, 2);

    cyc(1, 0, 0, 0, 0, 0);
    wr(1, 8'd255); wr(3, 8'd100);
    snap();
    runn(0, 257);
    idle(2);
    chk("stoch_ch0_zero", cnt[0] - base[0], 0);
    chk_ge("stoch_ch1_high", cnt[1] - base[1], 250);

    cyc(1, 0, 0, 0, 0, 0);
    wr(0, 8'd128);
    snap();
    runn(1, 5);
    cyc(0, 1, 1, 1, 0, 8'd255);
    runn(1, 7);
    idle(2);
    chk("midrun_write_ch0", cnt[0] - base[0], 9);

    cyc(1, 0, 0, 0, 0, 0);
    wr(0, 8'd128); wr(1, 8'd64); wr(4, 8'd90);
    snap();
    runn(1, 8);
    idle(1);
    runn(1, 8);
    idle(2);
    chk("restart_ch1_count", cnt[1] - base[1], 2);
    chk("restart_no_window", wd_cnt - wd_base, 0);
    runn(0, 8);
    idle(1);
    runn(0, 8);
    idle(1);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
    end

    for (int k = 0; k < 800; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) > 1, 1'($urandom),
          $urandom_range(0, 9) < 3, 3'($urandom), 8'($urandom));
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Rate-coding front end that sits directly upstream of the LIF network and drives its 8-bit per-neuron current input. Holds one 8-bit intensity per channel, loaded through a simple register-write port. While running, it converts each intensity into a spike train whose rate is proportional to the intensity. Two modes are supported: a stochastic mode using an LFSR comparator, and a deterministic mode using a phase accumulator. A window counter marks fixed observation windows for downstream rate readout.

Parameters:
N_CH, 8, number of channels; equals the width of the spikes output.
VAL_W, 8, intensity and accumulator width.
WINDOW, 16, steps per observation window; must be ≥2.
LFSR_SEED, 16'hACE1, LFSR reset and reload value; must be nonzero.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  intensity write strobe
wr_addr  in  $clog2(N_CH)  channel to write
wr_data  in  VAL_W  intensity value
run  in  1  encoder enable, level-sensitive
mode  in  1  0 = stochastic (LFSR), 1 = deterministic (accumulator); latched on IDLE→RUN
spikes  out  N_CH  registered spike vector; drives the network's current input
spike_valid  out  1  high on cycles where spikes holds a fresh step
window_done  out  1  one-cycle pulse on the last step of each window
busy  out  1  high while state is RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst all of the following are cleared:
  - intensity regs and accumulators = 0
  - lfsr = LFSR_SEED
  - state = IDLE, step_cnt = 0, mode_q = 0
  - all outputs = 0
  - Reset mid-RUN aborts immediately, with the same result.
- Writes: when wr_en is high, intensity[wr_addr] <= wr_data at the edge. Writes are accepted in any state. A write made during RUN is used from the next step. An out-of-range wr_addr (N_CH not a power of 2) is ignored.
- FSM states:
  - IDLE: spikes = 0, spike_valid = 0. When run is sampled high: go to RUN, mode_q <= mode, accumulators <= 0, step_cnt <= 0. The lfsr is not reloaded; it continues its sequence.
  - RUN, run high: one step per cycle.
  - RUN, run low: go to IDLE; spikes <= 0 and spike_valid <= 0 at that edge; lfsr holds its value.
- Latency: run sampled high at edge k (IDLE→RUN). The first step executes at edge k+1, and spikes/spike_valid are valid after edge k+1.
- Step, stochastic (mode_q = 0):
  - rnd_i = rotl8(lfsr[15:8], i) ^ lfsr[7:0]
  - spikes[i] <= (intensity[i] > rnd_i), compared unsigned
  - lfsr advances once per step as a Galois LFSR, right shift, mask 16'hB400
  - intensity 0 never spikes.
- Step, deterministic (mode_q = 1):
  - {c, acc_i} = acc_i + intensity[i], computed at VAL_W+1 bits
  - acc_i <= sum[VAL_W-1:0]; spikes[i] <= c
  - The long-run rate is exactly intensity/2^VAL_W. No saturation; the accumulator wraps.
- Window:
  - step_cnt increments on each step and wraps from WINDOW-1 to 0.
  - window_done = 1 in the same cycle spike_valid presents the step with step_cnt == WINDOW-1.
  - Leaving RUN early discards the partial window; no window_done pulse is produced.
- Simultaneous events:
  - rst overrides everything.
  - A write to channel i in the same cycle as a step: the step uses the old value.
  - run toggling every cycle is legal; each re-entry to RUN restarts the window and the accumulators.
- busy = (state == RUN), registered.

Decomposition:
- Package snn_pkg holds:
  - LFSR mask 16'hB400 and default seed
  - state enum {IDLE, RUN}
  - rotl8 function
- One natural sub-module: spike_lfsr16, holding the seed load, advance enable, and the 16-bit state output.
- Per-channel compare and accumulator logic stays inline in a generate loop.

Test Plan:
- Reset: assert rst for 2 cycles mid-RUN → spikes = 0, spike_valid = 0, busy = 0, window_done = 0. Then run=1 with mode=1 and intensity[0]=0 → no spikes.
- Deterministic, ch0 = 128, ch1 = 64, ch2 = 255, run for 16 steps:
  - ch0 pattern 0,1,0,1,… → 8 spikes
  - ch1 spikes on steps 4, 8, 12, 16 → 4 spikes
  - ch2 spikes on every step except step 1 → 15 spikes
  - window_done pulses exactly once, on step 16.
- Latency and window: run rises at edge k → spike_valid first high after edge k+1. Hold run for 40 steps → window_done pulses at steps 16 and 32 only.
- Stochastic, ch0 = 0, ch1 = 255, ch3 = 100, run for 256 steps → spike counts match a bit-exact LFSR model. ch0 count = 0; ch1 count ≥ 250.
- Mid-run write: mode=1, ch0=128. At step 5 write 255 → step 5 still uses 128; from step 6 onward ch0 spikes every step.
- Stop/restart: drop run at step 7 → spikes = 0 next cycle, no window_done. Re-raise run → step_cnt and accumulators restart at 0, and the spike pattern repeats from the start. In stochastic mode the lfsr continues rather than reloading.
